finger_input_conditioner: RTL and testbench

Upstream stage of the finger calculator. It conditions the four raw finger switches before they reach the finger decoder and accumulator. Each raw input is synchronised and debounced. A stable, nonzero finger pattern produces a single-cycle commit strobe, so one gesture counts exactly once. The block re-arms only after all fingers are released.

---
 rtl/finger_input_conditioner.sv | 150 +++++++++++++++
 tb/tb_finger_input_conditioner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/finger_input_conditioner.sv
// Conditions four raw finger switches: 2-flop sync, per-bit debounce, and a
// hold-then-commit FSM that emits one strobe per gesture and re-arms on full release.
module finger_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       d_o,
    output logic [3:0] pattern,
    output logic       commit,
    output logic       busy
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT_RELEASE
    } state_t;

    logic [3:0]    w_raw;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [DW-1:0] r_debCnt [4];
    logic [3:0]    r_clean;

    state_t        r_state;
    state_t        w_stateNext;
    logic [3:0]    r_cand;
    logic [3:0]    w_candNext;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_holdNext;
    logic          w_commitNext;
    logic [3:0]    r_pattern;
    logic          r_commit;
    logic          r_busy;

    assign w_raw = {d, c, b, a};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Each bit keeps its own run-length of disagreement with the clean value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_debCnt[i] <= '0;
            end
            r_clean <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_clean[i]) begin
                    r_debCnt[i] <= '0;
                end else if (r_debCnt[i] == DEB_LAST) begin
                    r_clean[i]  <= r_sync2[i];
                    r_debCnt[i] <= '0;
                end else begin
                    r_debCnt[i] <= r_debCnt[i] + DW'(1);
                end
            end
        end
    end

    // The hold counter starts at 1 because the edge that arms (or re-arms) the
    // timer is already one edge after the clean vector changed.
    always_comb begin
        w_stateNext  = r_state;
        w_candNext   = r_cand;
        w_holdNext   = r_hold;
        w_commitNext = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_clean != 4'd0) begin
                    w_stateNext = ARMED;
                    w_candNext  = r_clean;
                    w_holdNext  = HW'(1);
                end
            end
            ARMED: begin
                if (r_clean == 4'd0) begin
                    w_stateNext = IDLE;
                end else if (r_clean != r_cand) begin
                    w_candNext = r_clean;
                    w_holdNext = HW'(1);
                end else if (r_hold == HOLD_LAST) begin
                    w_commitNext = 1'b1;
                    w_stateNext  = WAIT_RELEASE;
                end else begin
                    w_holdNext = r_hold + HW'(1);
                end
            end
            WAIT_RELEASE: begin
                if (r_clean == 4'd0) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cand    <= '0;
            r_hold    <= '0;
            r_commit  <= 1'b0;
            r_pattern <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cand   <= w_candNext;
            r_hold   <= w_holdNext;
            r_commit <= w_commitNext;
            r_busy   <= (w_stateNext != IDLE);
            if (w_commitNext) begin
                r_pattern <= r_cand;
            end
        end
    end

    assign a_o     = r_clean[0];
    assign b_o     = r_clean[1];
    assign c_o     = r_clean[2];
    assign d_o     = r_clean[3];
    assign pattern = r_pattern;
    assign commit  = r_commit;
    assign busy    = r_busy;

endmodule

// File: tb/tb_finger_input_conditioner.sv
// Self-checking bench for finger_input_conditioner: constant vector table, directed
// multi-cycle sequences and random presses against a history-based reference model.
module tb_finger_input_conditioner;

    localparam int D    = 4;
    localparam int H    = 8;
    localparam int MAXE = 8191;

    logic       clk = 1'b0;
    logic       reset;
    logic       a, b, c, d;
    logic       a_o, b_o, c_o, d_o;
    logic [3:0] pattern;
    logic       commit;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int commitSeen = 0;

    // Reference model state: raw value sampled at each edge and clean vector after it.
    logic [3:0] rawHist [0:MAXE];
    logic [3:0] vHist   [0:MAXE];
    int         t;
    int         lastCommit;
    logic [3:0] expPattern;
    logic       expCommit;
    logic       expBusy;

    typedef struct {
        logic [3:0] raw;
        int         cycles;
        logic [3:0] expV;
        logic [3:0] expPat;
        logic       expC;
        logic       expB;
    } vec_t;

    vec_t vecTable [8];

    finger_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .reset(reset),
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .a_o(a_o),
        .b_o(b_o),
        .c_o(c_o),
        .d_o(d_o),
        .pattern(pattern),
        .commit(commit),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rawAt(input int k);
        return (k >= 1) ? rawHist[k] : 4'b0000;
    endfunction

    function automatic void modelReset();
        t          = 0;
        rawHist[0] = 4'b0000;
        vHist[0]   = 4'b0000;
        lastCommit = 0;
        expPattern = 4'b0000;
        expCommit  = 1'b0;
        expBusy    = 1'b0;
    endfunction

    // A clean bit flips once the synchronised value (raw two edges earlier) has
    // disagreed with it for D consecutive edges; a commit needs the clean vector
    // to have held one nonzero value for H edges since it last changed, with a
    // full release seen since the previous commit.
    function automatic void modelEdge(input logic [3:0] rawNow);
        logic [3:0] prev;
        logic [3:0] nextV;
        logic [3:0] r;
        logic [3:0] p;
        bit         allDiff;
        bit         runOk;
        bit         armed;
        if (t >= MAXE - 1) begin
            $display("[TB] FAIL modelCapacity: edge=%0d exceeds history limit %0d", t, MAXE);
            $fatal(1, "[TB] model history overflow");
        end
        t          = t + 1;
        rawHist[t] = rawNow;
        prev       = vHist[t-1];
        nextV      = prev;
        for (int i = 0; i < 4; i++) begin
            allDiff = 1'b1;
            for (int k = t - D - 1; k <= t - 2; k++) begin
                r = rawAt(k);
                if (r[i] == prev[i]) allDiff = 1'b0;
            end
            if (allDiff) nextV[i] = ~prev[i];
        end
        vHist[t]  = nextV;
        expBusy   = (vHist[t-1] != 4'b0000);
        expCommit = 1'b0;
        if (t >= H + 1) begin
            p     = vHist[t-1];
            runOk = (p != 4'b0000) && (vHist[t-H-1] != p);
            for (int k = t - H; k <= t - 1; k++) begin
                if (vHist[k] != p) runOk = 1'b0;
            end
            armed = 1'b0;
            for (int z = lastCommit; z <= t - H - 1; z++) begin
                if (vHist[z] == 4'b0000) armed = 1'b1;
            end
            if (runOk && armed) begin
                expCommit  = 1'b1;
                expPattern = p;
                lastCommit = t;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] eV, input logic [3:0] eP,
                               input logic eC, input logic eB);
        checks++;
        if ({d_o, c_o, b_o, a_o} !== eV || pattern !== eP || commit !== eC || busy !== eB) begin
            errors++;
            $display("[TB] FAIL %s edge=%0d: got v=%b pattern=%b commit=%b busy=%b, expected v=%b pattern=%b commit=%b busy=%b",
                     name, t, {d_o, c_o, b_o, a_o}, pattern, commit, busy, eV, eP, eC, eB);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Drives a raw pattern for n edges; entered and left just after a falling edge.
    task automatic applyStimulus(input logic [3:0] raw, input int n);
        for (int i = 0; i < n; i++) begin
            {d, c, b, a} = raw;
            @(posedge clk);
            modelEdge(raw);
            @(negedge clk);
            checkOutput("model", vHist[t], expPattern, expCommit, expBusy);
            if (commit === 1'b1) commitSeen++;
        end
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases on a falling edge.
    task automatic doReset(input logic [3:0] raw);
        #2;
        reset = 1'b1;
        {d, c, b, a} = raw;
        #1;
        checkOutput("asyncReset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        commitSeen = 0;
    endtask

    initial begin
        vecTable[0] = '{4'b0001, 5, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecTable[1] = '{4'b0001, 1, 4'b0001, 4'b0000, 1'b0, 1'b0};
        vecTable[2] = '{4'b0001, 7, 4'b0001, 4'b0000, 1'b0, 1'b1};
        vecTable[3] = '{4'b0001, 1, 4'b0001, 4'b0001, 1'b1, 1'b1};
        vecTable[4] = '{4'b0001, 1, 4'b0001, 4'b0001, 1'b0, 1'b1};
        vecTable[5] = '{4'b0000, 5, 4'b0001, 4'b0001, 1'b0, 1'b1};
        vecTable[6] = '{4'b0000, 1, 4'b0000, 4'b0001, 1'b0, 1'b1};
        vecTable[7] = '{4'b0000, 5, 4'b0000, 4'b0001, 1'b0, 1'b0};

        reset = 1'b0;
        {d, c, b, a} = 4'b0000;
        modelReset();

        doReset(4'b0000);
        applyStimulus(4'b0000, 50);
        checkValue("idleNoCommit", commitSeen, 0);

        applyStimulus(4'b0001, 3);
        applyStimulus(4'b0000, 15);
        checkValue("glitchNoCommit", commitSeen, 0);
        checkValue("glitchNoBusy", int'(busy), 0);

        doReset(4'b0000);
        foreach (vecTable[r]) begin
            for (int j = 0; j < vecTable[r].cycles; j++) begin
                applyStimulus(vecTable[r].raw, 1);
                checkOutput("vecTable", vecTable[r].expV, vecTable[r].expPat,
                            vecTable[r].expC, vecTable[r].expB);
            end
        end
        checkValue("singlePressCommits", commitSeen, 1);

        doReset(4'b0000);
        applyStimulus(4'b0001, 5);
        applyStimulus(4'b0011, 30);
        checkValue("staggerCommits", commitSeen, 1);
        checkValue("staggerPattern", int'(pattern), 3);

        doReset(4'b0000);
        applyStimulus(4'b0101, 100);
        checkValue("holdCommits", commitSeen, 1);
        checkValue("holdPattern", int'(pattern), 5);
        commitSeen = 0;
        applyStimulus(4'b0111, 40);
        checkValue("changeWhileHeldCommits", commitSeen, 0);
        checkValue("changeWhileHeldPattern", int'(pattern), 5);
        applyStimulus(4'b0000, 12);
        checkValue("releaseBusy", int'(busy), 0);
        applyStimulus(4'b0010, 30);
        checkValue("repressCommits", commitSeen, 1);
        checkValue("repressPattern", int'(pattern), 2);

        doReset(4'b0000);
        applyStimulus(4'b0001, 6);
        applyStimulus(4'b0001, 4);
        checkValue("armedBeforeReset", int'(busy), 1);
        checkValue("armedNoCommitYet", commitSeen, 0);
        doReset(4'b0001);
        applyStimulus(4'b0001, 20);
        checkValue("afterResetCommits", commitSeen, 1);
        checkValue("afterResetPattern", int'(pattern), 1);

        doReset(4'b0000);
        for (int s = 0; s < 300; s++) begin
            logic [3:0] rv;
            rv = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            applyStimulus(rv, int'($urandom_range(1, 16)));
        end
        applyStimulus(4'b0000, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
